// File: rtl/ama_riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// ama_riscv_dmem_responder : byte-maskable word SRAM behind the core's dmem port
// Rev 1.0 - initial release
// ============================================================================
module ama_riscv_dmem_responder #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_en,
    input  logic [3:0]  dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_ready,
    output logic        dmem_ack,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic        dmem_stall
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [2:0] CNT_LOAD = 3'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          cnt;
    logic [2:0]          cnt_nxt;
    logic                commit;
    logic [3:0]          cmt_we;
    logic [31:0]         cmt_addr;
    logic [31:0]         cmt_wdata;
    logic                cmt_oor;
    logic [ADDR_W-1:0]   cmt_idx;
    logic                mem_wr;
    logic                unused_addr_lsb;
    logic [31:0]         mem [DEPTH];

    // Outputs depend on state only, so the stall path never sees dmem_en.
    assign dmem_ready = (state != S_WAIT);
    assign dmem_stall = (state == S_WAIT);
    assign dmem_ack   = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = S_DONE;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                if (dmem_en) begin
                    if (WAIT_CYC == 0) begin
                        state_nxt = S_DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    generate
        if (WAIT_CYC == 0) begin : g_direct
            // Zero wait states commit on the accepting edge, straight from the port.
            assign cmt_we    = dmem_we;
            assign cmt_addr  = dmem_addr;
            assign cmt_wdata = dmem_wdata;
        end else begin : g_held
            logic [3:0]  req_we;
            logic [31:0] req_addr;
            logic [31:0] req_wdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    req_we    <= 4'd0;
                    req_addr  <= 32'd0;
                    req_wdata <= 32'd0;
                end else if (dmem_en && dmem_ready) begin
                    req_we    <= dmem_we;
                    req_addr  <= dmem_addr;
                    req_wdata <= dmem_wdata;
                end
            end

            assign cmt_we    = req_we;
            assign cmt_addr  = req_addr;
            assign cmt_wdata = req_wdata;
        end

        if (ADDR_W + 2 < 32) begin : g_range_chk
            assign cmt_oor = |cmt_addr[31:ADDR_W+2];
        end else begin : g_range_full
            assign cmt_oor = 1'b0;
        end
    endgenerate

    assign cmt_idx         = cmt_addr[ADDR_W+1:2];
    assign unused_addr_lsb = ^cmt_addr[1:0];
    assign mem_wr          = commit && !cmt_oor && rst_n;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (cmt_we[i]) begin
                    mem[cmt_idx][8*i +: 8] <= cmt_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            dmem_rdata <= 32'd0;
            dmem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dmem_err <= commit && cmt_oor;
            if (commit && (cmt_we == 4'b0000)) begin
                dmem_rdata <= cmt_oor ? 32'd0 : mem[cmt_idx];
            end
        end
    end

endmodule
`default_nettype wire
